// File: rtl/pooling_ctrl_pkg.sv
// Shared definitions for the 2x2 max-pool sequencer: FSM encoding and counter widths.
package pooling_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int COL_W     = cnt_w(DEF_IMG_W);
    localparam int PAIR_W    = cnt_w(DEF_IMG_H / 2);

endpackage

// File: rtl/pooling_2x2.sv
// 2x2 signed max-pool datapath: a two-column shift window and a combinational max tree.
module pooling_2x2 #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic signed [BIT_WIDTH-1:0] in1,
    input  logic signed [BIT_WIDTH-1:0] in2,
    output logic signed [BIT_WIDTH-1:0] max_out
);

    // [0]/[1] = older column (upper/lower), [2]/[3] = newest column.
    logic signed [BIT_WIDTH-1:0] win_reg [4];
    logic signed [BIT_WIDTH-1:0] max_a;
    logic signed [BIT_WIDTH-1:0] max_b;

    always_ff @(posedge clk) begin
        if (en) begin
            win_reg[0] <= win_reg[2];
            win_reg[1] <= win_reg[3];
            win_reg[2] <= in1;
            win_reg[3] <= in2;
        end
    end

    always_comb begin
        max_a   = (win_reg[0] > win_reg[1]) ? win_reg[0] : win_reg[1];
        max_b   = (win_reg[2] > win_reg[3]) ? win_reg[2] : win_reg[3];
        max_out = (max_a > max_b) ? max_a : max_b;
    end

endmodule

// File: rtl/pooling_ctrl.sv
// Frame sequencer for the 2x2 max-pool datapath: accepts column pairs, captures one
// pooled result per two columns and streams them out with a frame-final marker.
module pooling_ctrl
    import pooling_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] in1,
    input  logic signed [BIT_WIDTH-1:0] in2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int PW = cnt_w(IMG_H / 2);

    generate
        if ((IMG_W % 2) != 0) begin : g_bad_img_w
            $error("pooling_ctrl: IMG_W must be even");
        end
        if ((IMG_H % 2) != 0) begin : g_bad_img_h
            $error("pooling_ctrl: IMG_H must be even");
        end
    endgenerate

    state_t                      state_reg;
    state_t                      state_next;
    logic [CW-1:0]               col_reg;
    logic [PW-1:0]               pair_reg;
    logic                        cap_pend_reg;
    logic                        out_valid_reg;
    logic                        out_last_reg;
    logic signed [BIT_WIDTH-1:0] out_data_reg;

    logic                        accept;
    logic                        col_last;
    logic                        pair_last;
    logic                        out_hs;
    logic signed [BIT_WIDTH-1:0] pool_max;

    assign col_last  = (col_reg == CW'(IMG_W - 1));
    assign pair_last = (pair_reg == PW'(IMG_H / 2 - 1));
    assign out_hs    = out_valid_reg && out_ready;
    assign accept    = in_valid && in_ready;

    pooling_2x2 #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_pool (
        .clk    (clk),
        .en     (accept),
        .in1    (in1),
        .in2    (in2),
        .max_out(pool_max)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                // Input stalls while a capture is pending or the output slot is still occupied.
                in_ready = !cap_pend_reg && (!out_valid_reg || out_ready);
                if (in_valid && in_ready && col_last && pair_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_hs && out_last_reg) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            col_reg       <= '0;
            pair_reg      <= '0;
            cap_pend_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg <= state_next;

            if (cap_pend_reg) cap_pend_reg <= 1'b0;

            if (state_reg == ST_IDLE && start) begin
                col_reg      <= '0;
                pair_reg     <= '0;
                cap_pend_reg <= 1'b0;
            end else if (accept) begin
                cap_pend_reg <= col_reg[0];
                if (col_last) begin
                    col_reg  <= '0;
                    pair_reg <= pair_last ? '0 : pair_reg + PW'(1);
                end else begin
                    col_reg  <= col_reg + CW'(1);
                end
            end

            if (out_hs) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
            // The final capture always happens in DRAIN, which is what marks it as last.
            if (cap_pend_reg) begin
                out_data_reg  <= pool_max;
                out_valid_reg <= 1'b1;
                out_last_reg  <= (state_reg == ST_DRAIN);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_pooling_ctrl.sv
// Directed bench for pooling_ctrl: a 4x4 instance for most scenarios and a 6x2 instance for row width.
module tb_pooling_ctrl;

    localparam int BW = 32;
    localparam logic signed [BW-1:0] MINV = {1'b1, {(BW-1){1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic sel6 = 1'b0;
    logic signed [BW-1:0] in1 = '0;
    logic signed [BW-1:0] in2 = '0;

    logic rdy4, ov4, ol4, busy4, done4;
    logic rdy6, ov6, ol6, busy6, done6;
    logic signed [BW-1:0] od4, od6;

    logic in_ready_m, out_valid_m, out_last_m, busy_m, done_m;
    logic signed [BW-1:0] out_data_m;

    assign in_ready_m  = sel6 ? rdy6  : rdy4;
    assign out_valid_m = sel6 ? ov6   : ov4;
    assign out_last_m  = sel6 ? ol6   : ol4;
    assign out_data_m  = sel6 ? od6   : od4;
    assign busy_m      = sel6 ? busy6 : busy4;
    assign done_m      = sel6 ? done6 : done4;

    pooling_ctrl #(.BIT_WIDTH(BW), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start && !sel6), .in_valid(in_valid && !sel6),
        .in_ready(rdy4), .in1(in1), .in2(in2), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_last(ol4), .busy(busy4), .done(done4)
    );

    pooling_ctrl #(.BIT_WIDTH(BW), .IMG_W(6), .IMG_H(2)) u_dut6 (
        .clk(clk), .rst(rst), .start(start && sel6), .in_valid(in_valid && sel6),
        .in_ready(rdy6), .in1(in1), .in2(in2), .out_valid(ov6), .out_ready(out_ready),
        .out_data(od6), .out_last(ol6), .busy(busy6), .done(done6)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_count = 0;
    int acc_count = 0;
    int hs_cyc = 0;
    int done_cyc = 0;
    logic signed [BW-1:0] q_data[$];
    logic                 q_last[$];

    logic signed [BW-1:0] px1 [8];
    logic signed [BW-1:0] px2 [8];
    int n_px = 8;
    logic signed [BW-1:0] exp_d [4];
    logic                 exp_l [4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid_m && out_ready) begin
            q_data.push_back(out_data_m);
            q_last.push_back(out_last_m);
            hs_cyc = cyc;
        end
        if (in_valid && in_ready_m) acc_count++;
        if (done_m) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic load_basic();
        px1 = '{1, 3, 7, -8, -1, -3, 10, 4};
        px2 = '{5, -2, 0, -9, -2, -4, 2, 11};
        n_px = 8;
        exp_d = '{5, 7, -1, 11};
        exp_l = '{0, 0, 0, 1};
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        acc_count = 0;
    endtask

    task automatic drive_pair(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b,
                              output bit got);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready_m) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit bubble, output bit ok);
        bit got;
        int d0;
        ok = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < n_px; i++) begin
            drive_pair(px1[i], px2[i], got);
            if (!got) ok = 1'b0;
            if (bubble) begin
                @(posedge clk);
                #1;
            end
        end
        d0 = done_count;
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            if (done_count != d0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 6;
        if (out_valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_m); end
        if (out_last_m !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last_m); end
        if (out_data_m !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data_m); end
        if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
        if (done_m !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_m); end
        if (in_ready_m !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_m); end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        load_basic();
        clear_mon();
        d0 = done_count;
        run_frame(1'b0, ok);
        n_checks += 4;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: got stall expected completion"); end
        if (q_data.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", q_data.size()); end
        if (done_count - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_count - d0); end
        if (done_cyc != hs_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: got %0d expected %0d", done_cyc - hs_cyc, 1); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > i) begin
                n_checks += 2;
                if (q_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, q_data[i], exp_d[i]); end
                if (q_last[i] !== exp_l[i]) begin n_fail++; $display("FAIL basic_last[%0d]: got %b expected %b", i, q_last[i], exp_l[i]); end
            end
        end
        @(negedge clk);
        n_checks += 2;
        if (busy_m !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy_m); end
        if (done_m !== 1'b0) begin n_fail++; $display("FAIL basic_done_after: got %b expected 0", done_m); end
        $display("test_basic: %0d results", q_data.size());
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        load_basic();
        clear_mon();
        out_ready = 1'b0;
        fork
            run_frame(1'b0, ok);
            begin
                seen = 1'b0;
                for (int t = 0; t < 60; t++) begin
                    @(negedge clk);
                    if (out_valid_m) begin
                        seen = 1'b1;
                        break;
                    end
                end
                n_checks++;
                if (!seen) begin n_fail++; $display("FAIL bp_first_valid: got none expected out_valid"); end
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    n_checks += 3;
                    if (out_valid_m !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, out_valid_m); end
                    if (out_data_m !== 5) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %0d expected 5", c, out_data_m); end
                    if (in_ready_m !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready_m); end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: got stall expected completion"); end
        if (q_data.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > i) begin
                n_checks++;
                if (q_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, q_data[i], exp_d[i]); end
            end
        end
        $display("test_backpressure: %0d results", q_data.size());
    endtask

    task automatic test_bubbles();
        bit ok;
        load_basic();
        clear_mon();
        run_frame(1'b1, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL bubble_timeout: got stall expected completion"); end
        if (q_data.size() != 4) begin n_fail++; $display("FAIL bubble_count: got %0d expected 4", q_data.size()); end
        if (acc_count != 8) begin n_fail++; $display("FAIL bubble_accepts: got %0d expected 8", acc_count); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > i) begin
                n_checks += 2;
                if (q_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL bubble_data[%0d]: got %0d expected %0d", i, q_data[i], exp_d[i]); end
                if (q_last[i] !== exp_l[i]) begin n_fail++; $display("FAIL bubble_last[%0d]: got %b expected %b", i, q_last[i], exp_l[i]); end
            end
        end
        $display("test_bubbles: %0d results, %0d accepts", q_data.size(), acc_count);
    endtask

    task automatic test_negative();
        bit ok;
        int k1 [8];
        int k2 [8];
        int ke [4];
        k1 = '{3, 0, 5, 6, 0, 0, 7, 2};
        k2 = '{1, 2, 4, 0, 0, 1, 2, 2};
        ke = '{3, 6, 1, 7};
        for (int i = 0; i < 8; i++) begin
            px1[i] = MINV + BW'(k1[i]);
            px2[i] = MINV + BW'(k2[i]);
        end
        n_px = 8;
        clear_mon();
        run_frame(1'b0, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL neg_timeout: got stall expected completion"); end
        if (q_data.size() != 4) begin n_fail++; $display("FAIL neg_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > i) begin
                n_checks++;
                if (q_data[i] !== MINV + BW'(ke[i])) begin
                    n_fail++;
                    $display("FAIL neg_data[%0d]: got %0d expected %0d", i, q_data[i], MINV + BW'(ke[i]));
                end
            end
        end
        $display("test_negative: %0d results", q_data.size());
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit got;
        int d0;
        load_basic();
        d0 = done_count;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 5; i++) drive_pair(px1[i], px2[i], got);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (out_valid_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid_m); end
        if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_m); end
        if (in_ready_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready_m); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_count != d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected %0d", done_count, d0); end
        clear_mon();
        run_frame(1'b0, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL rstmid_rerun_timeout: got stall expected completion"); end
        if (q_data.size() != 4) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > i) begin
                n_checks += 2;
                if (q_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %0d expected %0d", i, q_data[i], exp_d[i]); end
                if (q_last[i] !== exp_l[i]) begin n_fail++; $display("FAIL rstmid_last[%0d]: got %b expected %b", i, q_last[i], exp_l[i]); end
            end
        end
        $display("test_reset_midframe: %0d results after restart", q_data.size());
    endtask

    task automatic test_start_in_run();
        bit ok;
        int d0;
        load_basic();
        clear_mon();
        d0 = done_count;
        fork
            run_frame(1'b0, ok);
            begin
                repeat (5) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL startrun_timeout: got stall expected completion"); end
        if (q_data.size() != 4) begin n_fail++; $display("FAIL startrun_count: got %0d expected 4", q_data.size()); end
        if (done_count - d0 != 1) begin n_fail++; $display("FAIL startrun_done: got %0d expected 1", done_count - d0); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > i) begin
                n_checks++;
                if (q_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL startrun_data[%0d]: got %0d expected %0d", i, q_data[i], exp_d[i]); end
            end
        end
        $display("test_start_in_run: %0d results", q_data.size());
    endtask

    task automatic test_img_w6();
        bit ok;
        logic signed [BW-1:0] e6 [3];
        logic                 l6 [3];
        e6 = '{4, -1, 9};
        l6 = '{0, 0, 1};
        px1[0:5] = '{1, 3, -5, -7, 9, 0};
        px2[0:5] = '{2, 4, -6, -1, 0, 8};
        n_px = 6;
        sel6 = 1'b1;
        clear_mon();
        run_frame(1'b0, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL w6_timeout: got stall expected completion"); end
        if (q_data.size() != 3) begin n_fail++; $display("FAIL w6_count: got %0d expected 3", q_data.size()); end
        for (int i = 0; i < 3; i++) begin
            if (q_data.size() > i) begin
                n_checks += 2;
                if (q_data[i] !== e6[i]) begin n_fail++; $display("FAIL w6_data[%0d]: got %0d expected %0d", i, q_data[i], e6[i]); end
                if (q_last[i] !== l6[i]) begin n_fail++; $display("FAIL w6_last[%0d]: got %b expected %b", i, q_last[i], l6[i]); end
            end
        end
        @(posedge clk);
        #1 sel6 = 1'b0;
        $display("test_img_w6: %0d results", q_data.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_negative();
        test_reset_midframe();
        test_start_in_run();
        test_img_w6();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
